// File: rtl/camo_key_loader.sv
// camo_key_loader: serial key-provisioning front end for a MUX-locked netlist.
// Receives a key frame one bit per cycle (LSB first) over valid/ready, checks
// its length and optionally its trailing even-parity bit, and only then drives
// key_out. Consecutive rejected frames lead to a lockout that only rst clears.
// Optional feature macro: CAMO_KEY_CHECK_EN (trailing even-parity bit per frame).
module camo_key_loader #(
  parameter int unsigned KEY_W    = 2,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic             key_bit,
  input  logic             key_last,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_applied,
  output logic             key_err,
  output logic             lockout
);

`ifdef CAMO_KEY_CHECK_EN
  localparam int unsigned FL = KEY_W + 1;
`else
  localparam int unsigned FL = KEY_W;
`endif
  localparam int unsigned CNT_W  = $clog2(FL + 1);
  localparam int unsigned FAIL_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_APPLIED = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [FL-1:0]     staging, staging_nxt;
  logic [FAIL_W-1:0] fail_cnt, fail_nxt, fail_inc;
  logic [KEY_W-1:0]  key_out_nxt;
  logic              applied_nxt, err_nxt, lock_nxt, ready_nxt;
  logic              xfer, reject, parity_ok;
  logic [CNT_W-1:0]  n;
  logic [FL:0]       shift_in;

  // State, counters, staging and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      staging     <= '0;
      fail_cnt    <= '0;
      key_out     <= '0;
      key_applied <= 1'b0;
      key_err     <= 1'b0;
      lockout     <= 1'b0;
      key_ready   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      staging     <= staging_nxt;
      fail_cnt    <= fail_nxt;
      key_out     <= key_out_nxt;
      key_applied <= applied_nxt;
      key_err     <= err_nxt;
      lockout     <= lock_nxt;
      key_ready   <= ready_nxt;
    end
  end

  // Next-state, frame checking and next output values
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    staging_nxt = staging;
    fail_nxt    = fail_cnt;
    key_out_nxt = key_out;
    applied_nxt = key_applied;
    err_nxt     = 1'b0;
    reject      = 1'b0;

    xfer     = key_valid && key_ready;
    // A frame starts fresh from IDLE/APPLIED; only SHIFT continues one
    n        = (state == S_SHIFT) ? cnt + CNT_W'(1) : CNT_W'(1);
    shift_in = {key_bit, ((state == S_SHIFT) ? staging : {FL{1'b0}})};
    fail_inc = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);
`ifdef CAMO_KEY_CHECK_EN
    parity_ok = ~(^staging);
`else
    parity_ok = 1'b1;
`endif

    case (state)
      S_IDLE, S_SHIFT, S_APPLIED: begin
        if (xfer) begin
          staging_nxt = shift_in[FL:1];
          if (key_last) begin
            if (n == CNT_W'(FL)) begin
              state_nxt = S_CHECK;
              cnt_nxt   = '0;
            end else begin
              reject = 1'b1;
            end
          end else if (n == CNT_W'(FL)) begin
            reject = 1'b1;
          end else begin
            state_nxt = S_SHIFT;
            cnt_nxt   = n;
          end
        end
      end
      S_CHECK: begin
        if (parity_ok) begin
          key_out_nxt = staging[KEY_W-1:0];
          applied_nxt = 1'b1;
          fail_nxt    = '0;
          state_nxt   = S_APPLIED;
        end else begin
          reject = 1'b1;
        end
      end
      S_LOCKOUT: begin
        state_nxt = S_LOCKOUT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Any rejection destroys the current key and counts toward lockout
    if (reject) begin
      err_nxt     = 1'b1;
      key_out_nxt = '0;
      applied_nxt = 1'b0;
      cnt_nxt     = '0;
      fail_nxt    = fail_inc;
      state_nxt   = (fail_inc >= FAIL_W'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
    end

    if (state_nxt == S_LOCKOUT) begin
      key_out_nxt = '0;
      applied_nxt = 1'b0;
    end

    lock_nxt  = (state_nxt == S_LOCKOUT);
    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_SHIFT) ||
                (state_nxt == S_APPLIED);
  end

endmodule

// File: tb/tb_camo_key_loader.sv
// tb_camo_key_loader: directed self-checking bench for camo_key_loader
// (KEY_W=2, MAX_FAIL=3). Expectations follow CAMO_KEY_CHECK_EN when defined.
module tb_camo_key_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic       key_bit;
  logic       key_last;
  logic       key_ready;
  logic [1:0] key_out;
  logic       key_applied;
  logic       key_err;
  logic       lockout;

  int n_tests = 0;
  int n_fail  = 0;

  camo_key_loader #(.KEY_W(2), .MAX_FAIL(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_last   (key_last),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .key_applied(key_applied),
    .key_err    (key_err),
    .lockout    (lockout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit presented for one clock edge; returns 1 time unit after the edge
  task automatic xfer(input logic b, input logic last);
    key_valid = 1'b1;
    key_bit   = b;
    key_last  = last;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   64'(key_ready),   64'd1);
    check({tag, "_out"},     64'(key_out),     64'd0);
    check({tag, "_applied"}, 64'(key_applied), 64'd0);
    check({tag, "_err"},     64'(key_err),     64'd0);
    check({tag, "_lockout"}, 64'(lockout),     64'd0);
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_bit = 1'b0; key_last = 1'b0;
    @(negedge clk);
    do_reset();
    check_reset_vals("rst0");

`ifdef CAMO_KEY_CHECK_EN
    // Good frame 0,1,1 -> key 2'b10
    xfer(1'b0, 1'b0); xfer(1'b1, 1'b0); xfer(1'b1, 1'b1);
    check("good_t1_ready", 64'(key_ready), 64'd0);
    check("good_t1_err",   64'(key_err),   64'd0);
    step();
    check("good_out",     64'(key_out),     64'h2);
    check("good_applied", 64'(key_applied), 64'd1);
    check("good_err",     64'(key_err),     64'd0);
    check("good_ready",   64'(key_ready),   64'd1);

    // From APPLIED: 2-bit frame with early key_last -> error at t+1
    xfer(1'b1, 1'b0);
    check("reload_hold_out", 64'(key_out), 64'h2);
    xfer(1'b1, 1'b1);
    check("early_err",     64'(key_err),     64'd1);
    check("early_out",     64'(key_out),     64'd0);
    check("early_applied", 64'(key_applied), 64'd0);
    check("early_ready",   64'(key_ready),   64'd1);

    // Good frame clears the fail counter
    xfer(1'b0, 1'b0); xfer(1'b1, 1'b0); xfer(1'b1, 1'b1);
    step();
    check("good2_out", 64'(key_out), 64'h2);

    // Bad parity 0,1,0 -> key_err at t+2
    xfer(1'b0, 1'b0); xfer(1'b1, 1'b0); xfer(1'b0, 1'b1);
    check("par_t1_err",   64'(key_err),   64'd0);
    check("par_t1_ready", 64'(key_ready), 64'd0);
    step();
    check("par_err",     64'(key_err),     64'd1);
    check("par_out",     64'(key_out),     64'd0);
    check("par_applied", 64'(key_applied), 64'd0);
    check("par_ready",   64'(key_ready),   64'd1);
    check("par_lockout", 64'(lockout),     64'd0);
    step();
    check("par_err_pulse", 64'(key_err), 64'd0);

    // Abort by rst mid-frame, then good frame 1,0,1 -> 2'b01
    xfer(1'b1, 1'b0);
    do_reset();
    check("abort_err", 64'(key_err), 64'd0);
    xfer(1'b1, 1'b0); xfer(1'b0, 1'b0); xfer(1'b1, 1'b1);
    step();
    check("after_abort_out",     64'(key_out),     64'h1);
    check("after_abort_applied", 64'(key_applied), 64'd1);
`else
    // Good frame 1,1 -> key 2'b11
    xfer(1'b1, 1'b0); xfer(1'b1, 1'b1);
    check("good_t1_ready", 64'(key_ready), 64'd0);
    check("good_t1_err",   64'(key_err),   64'd0);
    step();
    check("good_out",     64'(key_out),     64'h3);
    check("good_applied", 64'(key_applied), 64'd1);
    check("good_err",     64'(key_err),     64'd0);
    check("good_ready",   64'(key_ready),   64'd1);

    // 3-bit frame without key_last by bit 2 -> error on second transfer
    xfer(1'b0, 1'b0);
    check("long_b1_err", 64'(key_err), 64'd0);
    check("long_b1_out", 64'(key_out), 64'h3);
    xfer(1'b1, 1'b0);
    check("long_err",     64'(key_err),     64'd1);
    check("long_out",     64'(key_out),     64'd0);
    check("long_applied", 64'(key_applied), 64'd0);
    check("long_ready",   64'(key_ready),   64'd1);

    // Early key_last on first bit -> second consecutive failure
    xfer(1'b1, 1'b1);
    check("early_err",     64'(key_err), 64'd1);
    check("early_lockout", 64'(lockout), 64'd0);
    step();
    check("early_err_pulse", 64'(key_err), 64'd0);

    // Good frame clears fail counter; one more bad must not lock out
    xfer(1'b0, 1'b0); xfer(1'b1, 1'b1);
    step();
    check("good2_out", 64'(key_out), 64'h2);
    xfer(1'b1, 1'b1);
    check("clr_err",     64'(key_err), 64'd1);
    check("clr_lockout", 64'(lockout), 64'd0);

    // Abort by rst mid-frame, then good frame 1,0 -> 2'b01
    xfer(1'b1, 1'b0);
    do_reset();
    check("abort_err", 64'(key_err), 64'd0);
    xfer(1'b1, 1'b0); xfer(1'b0, 1'b1);
    step();
    check("after_abort_out",     64'(key_out),     64'h1);
    check("after_abort_applied", 64'(key_applied), 64'd1);
`endif

    // Three consecutive bad frames -> lockout after the third
    xfer(1'b1, 1'b1);
    check("lk1_lockout", 64'(lockout), 64'd0);
    check("lk1_out",     64'(key_out), 64'd0);
    xfer(1'b1, 1'b1);
    check("lk2_lockout", 64'(lockout), 64'd0);
    xfer(1'b1, 1'b1);
    check("lk3_err",     64'(key_err),   64'd1);
    check("lk3_lockout", 64'(lockout),   64'd1);
    check("lk3_ready",   64'(key_ready), 64'd0);
    // Frames offered during lockout are ignored
    for (int i = 0; i < 4; i++) xfer(1'b1, (i == 3));
    step(); step();
    check("lk_ignore_out",     64'(key_out),     64'd0);
    check("lk_ignore_applied", 64'(key_applied), 64'd0);
    check("lk_ignore_err",     64'(key_err),     64'd0);
    check("lk_hold",           64'(lockout),     64'd1);
    check("lk_hold_ready",     64'(key_ready),   64'd0);

    do_reset();
    check_reset_vals("rst1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
